// File: rtl/l2_request_arbiter_pkg.sv
// l2_request_arbiter_pkg
//   Shared types and constants for the L2 request arbiter slice:
//   - NUM_CORES, CACHE_LINE_BITS, L2_STARVE_LIMIT: default sizing.
//   - l2req_op_t: L2 request opcode.
//   - l2req_packet_t: request packet carried from requesters to the tag stage.
//   - fill_op_legal(): ops that a memory restart (fill) may carry.
package l2_request_arbiter_pkg;

   localparam int NUM_CORES       = 4;
   localparam int CACHE_LINE_BITS = 128;
   localparam int L2_STARVE_LIMIT = 8;
   localparam int L2_ADDR_WIDTH   = 32;

   typedef enum logic [2:0] {
      L2REQ_LOAD        = 3'd0,
      L2REQ_STORE       = 3'd1,
      L2REQ_FLUSH       = 3'd2,
      L2REQ_DINVALIDATE = 3'd3,
      L2REQ_IINVALIDATE = 3'd4,
      L2REQ_LOAD_SYNC   = 3'd5,
      L2REQ_STORE_SYNC  = 3'd6
   } l2req_op_t;

   typedef struct packed {
      logic                     valid;
      l2req_op_t                op;
      logic [3:0]               core;
      logic [L2_ADDR_WIDTH-1:0] address;
   } l2req_packet_t;

   // Flushes and data invalidates never miss, so they can never come back
   // through the restart path.
   function automatic logic fill_op_legal(input l2req_op_t op);
      return !(op inside {L2REQ_FLUSH, L2REQ_DINVALIDATE});
   endfunction

endpackage

// File: rtl/l2_request_arbiter_if.sv
// l2_request_arbiter_if
//   Bundle between the L2 requesters (cores + memory fill path), the
//   arbiter and the downstream tag stage.
//   Ports (signals):
//     core_l2req_valid/core_l2req_packet  per-core requests
//     arb_core_ack                        one-hot core grant
//     fill_valid/fill_l2req_packet/fill_data  memory restart request
//     arb_fill_ack                        fill grant
//     stall_pipeline                      downstream back-pressure
//     arb_l2req_packet/arb_is_l2_fill/arb_data_from_memory  registered result
//   Modports: slave = arbiter, master = requesters + downstream stage.
//
// Handshake: a requester raises *_valid and holds it together with its
// packet (and fill_data) unchanged until it sees its ack. An ack is a
// combinational response in the same cycle and is only ever raised for a
// requester whose valid is high; the transfer happens on the clock edge
// that ends the ack cycle, and the requester may present its next request
// from the following cycle. While stall_pipeline is high no ack is raised.
interface l2_request_arbiter_if
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = NUM_CORES
);

   logic [NUM_REQUESTERS-1:0]  core_l2req_valid;
   l2req_packet_t              core_l2req_packet [NUM_REQUESTERS];
   logic [NUM_REQUESTERS-1:0]  arb_core_ack;

   logic                       fill_valid;
   l2req_packet_t              fill_l2req_packet;
   logic [CACHE_LINE_BITS-1:0] fill_data;
   logic                       arb_fill_ack;

   logic                       stall_pipeline;

   l2req_packet_t              arb_l2req_packet;
   logic                       arb_is_l2_fill;
   logic [CACHE_LINE_BITS-1:0] arb_data_from_memory;

   modport slave (
      input  core_l2req_valid, core_l2req_packet,
      output arb_core_ack,
      input  fill_valid, fill_l2req_packet, fill_data,
      output arb_fill_ack,
      input  stall_pipeline,
      output arb_l2req_packet, arb_is_l2_fill, arb_data_from_memory
   );

   modport master (
      output core_l2req_valid, core_l2req_packet,
      input  arb_core_ack,
      output fill_valid, fill_l2req_packet, fill_data,
      input  arb_fill_ack,
      output stall_pipeline,
      input  arb_l2req_packet, arb_is_l2_fill, arb_data_from_memory
   );

endinterface

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// rr_arbiter
//   Generic round-robin arbiter. The grant is the first set request bit at
//   or after rr_ptr in circular order; the pointer moves to one past the
//   winner only when update_lru is asserted, so the caller decides whether
//   the grant was actually consumed.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     request       request vector
//     update_lru    advance the pointer past the current winner
//     grant_oh      one-hot grant (combinational)
//     grant_idx     binary index of the winner
//     grant_valid   some request is set
//     rr_ptr        current priority pointer (also useful for debug)
module rr_arbiter #(
   parameter  int NUM_REQUESTERS = 4,
   localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      update_lru,
   output logic [NUM_REQUESTERS-1:0] grant_oh,
   output logic [PTR_W-1:0]          grant_idx,
   output logic                      grant_valid,
   output logic [PTR_W-1:0]          rr_ptr
);

   // One extra bit so rr_ptr + offset never overflows before the wrap.
   localparam int CAND_W = PTR_W + 1;

   logic [CAND_W-1:0] cand;
   logic [PTR_W-1:0]  next_ptr;

   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         cand = {1'b0, rr_ptr} + CAND_W'(i);
         // Explicit wrap: NUM_REQUESTERS need not be a power of two.
         if (cand >= CAND_W'(NUM_REQUESTERS))
            cand = cand - CAND_W'(NUM_REQUESTERS);
         if (!grant_valid && request[cand[PTR_W-1:0]]) begin
            grant_valid                 = 1'b1;
            grant_idx                   = cand[PTR_W-1:0];
            grant_oh[cand[PTR_W-1:0]]   = 1'b1;
         end
      end
   end

   always_comb begin
      if (grant_idx == PTR_W'(NUM_REQUESTERS - 1))
         next_ptr = '0;
      else
         next_ptr = grant_idx + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr <= '0;
      else if (update_lru && grant_valid)
         rr_ptr <= next_ptr;
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
//   Front stage of the L2 pipeline. Each unstalled cycle it grants one of
//   the memory fill path or a core request and registers the winner into
//   the arb_* signals for the tag stage. Fills normally win so restarted
//   misses drain, but after STARVE_LIMIT consecutive fill grants with a
//   core waiting, one core is forced through. Cores rotate round-robin.
//   Ports:
//     clk, reset         clock, asynchronous active-high reset
//     bus                l2_request_arbiter_if.slave (requests, acks,
//                        stall, registered result)
//     dbg_rr_ptr         round-robin pointer
//     dbg_starve_count   consecutive fill grants while a core waited
module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter  int NUM_REQUESTERS = NUM_CORES,
   parameter  int STARVE_LIMIT   = L2_STARVE_LIMIT,
   localparam int PTR_W    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   l2_request_arbiter_if.slave  bus,
   output logic [PTR_W-1:0]     dbg_rr_ptr,
   output logic [STARVE_W-1:0]  dbg_starve_count
);

   logic [NUM_REQUESTERS-1:0] rr_grant_oh;
   logic [PTR_W-1:0]          rr_grant_idx;
   logic                      rr_grant_valid;
   logic [PTR_W-1:0]          rr_ptr;

   logic [STARVE_W-1:0]       starve_count;
   logic                      core_any;
   logic                      fill_wins;
   logic                      fill_grant;
   logic                      core_grant;
   l2req_packet_t             core_sel_pkt;
   l2req_packet_t             fill_sel_pkt;

   rr_arbiter #(
      .NUM_REQUESTERS(NUM_REQUESTERS)
   ) u_rr_arbiter (
      .clk        (clk),
      .reset      (reset),
      .request    (bus.core_l2req_valid),
      .update_lru (core_grant),
      .grant_oh   (rr_grant_oh),
      .grant_idx  (rr_grant_idx),
      .grant_valid(rr_grant_valid),
      .rr_ptr     (rr_ptr)
   );

   // Grant decision. Fill priority only yields once the starvation guard
   // is saturated and a core is actually waiting.
   always_comb begin
      core_any   = |bus.core_l2req_valid;
      fill_wins  = bus.fill_valid &&
                   (!core_any || (starve_count < STARVE_W'(STARVE_LIMIT)));
      fill_grant = !bus.stall_pipeline && fill_wins;
      core_grant = !bus.stall_pipeline && !fill_wins && rr_grant_valid;
   end

   assign bus.arb_core_ack = core_grant ? rr_grant_oh : '0;
   assign bus.arb_fill_ack = fill_grant;

   always_comb begin
      core_sel_pkt       = bus.core_l2req_packet[rr_grant_idx];
      core_sel_pkt.valid = 1'b1;
      fill_sel_pkt       = bus.fill_l2req_packet;
      fill_sel_pkt.valid = 1'b1;
   end

   // Starvation guard; frozen while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_count <= '0;
      end else if (!bus.stall_pipeline) begin
         if (core_grant)
            starve_count <= '0;
         else if (fill_grant && core_any) begin
            if (starve_count != STARVE_W'(STARVE_LIMIT))
               starve_count <= starve_count + STARVE_W'(1);
         end else if (!core_any)
            starve_count <= '0;
      end
   end

   // Output register loads every cycle; fill data is only captured on fill
   // grants so the tag stage sees the last line otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.arb_l2req_packet     <= '0;
         bus.arb_is_l2_fill       <= 1'b0;
         bus.arb_data_from_memory <= '0;
      end else if (fill_grant) begin
         bus.arb_l2req_packet     <= fill_sel_pkt;
         bus.arb_is_l2_fill       <= 1'b1;
         bus.arb_data_from_memory <= bus.fill_data;
      end else if (core_grant) begin
         bus.arb_l2req_packet     <= core_sel_pkt;
         bus.arb_is_l2_fill       <= 1'b0;
      end else begin
         bus.arb_l2req_packet     <= '0;
         bus.arb_is_l2_fill       <= 1'b0;
      end
   end

   assign dbg_rr_ptr       = rr_ptr;
   assign dbg_starve_count = starve_count;

   a_fill_op_legal : assert property (@(posedge clk) disable iff (reset)
      bus.arb_fill_ack |-> fill_op_legal(bus.fill_l2req_packet.op));

   a_ack_onehot0 : assert property (@(posedge clk) disable iff (reset)
      $onehot0({bus.arb_core_ack, bus.arb_fill_ack}));

endmodule
